exp_subt_sched: RTL and testbench
=================================

// Module: exp_subt_sched
// PURPOSE
//  Shares one exponent subtractor (Y = A - B) between N_REQ requesters.
//  Typical requesters: add/sub alignment, normalisation and log range-reduction.
//  Round-robin arbitration with valid/ready handshakes.
//  Two-stage pipeline: operand register, then result register.
//  Every result carries a requester tag and a borrow flag.
// PARAMETERS
//  P     8  exponent width: A operand and Y result
//  W     5  subtrahend width: B operand, W <= P
//  N_REQ 3  number of requesters, 2..8
//  ID_W  2  tag width, ID_W = clog2(N_REQ)
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  rst        in   1        asynchronous, active-low reset
//  req_valid  in   N_REQ    requester i has an operand pair
//  req_ready  out  N_REQ    one-hot; request i is accepted this cycle
//  req_a      in   N_REQ*P  packed A operands; slice i = [i*P +: P]
//  req_b      in   N_REQ*W  packed B operands; slice i = [i*W +: W]
//  res_valid  out  1        result register holds a valid result
//  res_ready  in   1        consumer accepts the result
//  res_y      out  P        (A - zero-extended B) mod 2^P
//  res_borrow out  1        1 when A < zero-extended B (underflow)
//  res_id     out  ID_W     requester index that issued the result
//  busy       out  1        either pipeline stage is occupied
// BEHAVIOUR
//  Reset (rst=0, async):
//   - both stage valids = 0; res_y, res_borrow, res_id = 0
//   - round-robin pointer = 0
//   - req_ready = 0 while reset is asserted
//  Handshakes:
//   - request i transfers when req_valid[i] && req_ready[i]
//   - result transfers when res_valid && res_ready
//   - req_ready is combinational from req_valid, the pointer and the stall state
//   - requesters hold valid/operands stable until accepted
//   - req_ready never depends on req_a or req_b
//  Arbitration:
//   - grant = first i with req_valid[i], scanning pointer, pointer+1, ... (mod N_REQ)
//   - pointer moves to grant+1 (mod N_REQ) only on an accepted transfer
//   - pointer wraps N_REQ-1 -> 0
//  Pipeline:
//   - S1 registers {A, B, id}
//   - S2 computes the subtraction from S1 and registers {Y, borrow, id}
//   - advance = !res_valid || res_ready
//   - S1 accepts when (!s1_valid || advance); S2 loads S1 when advance
//   - latency: accept at cycle t -> res_valid at t+2 with no stall
//   - throughput: 1 result per cycle
//  Arithmetic:
//   - B zero-extended to P bits; Y = A - B modulo 2^P
//   - borrow = carry-out of a (P+1)-bit subtract, i.e. A < B
//  Boundaries:
//   - back-pressure (res_ready=0, both stages full): req_ready = 0, all state held
//   - simultaneous result drain and new accept in one cycle: both occur, nothing lost
//   - no req_valid: pointer unchanged, S1 empties
//   - reset mid-operation: in-flight results are discarded, not replayed
// STRUCTURE
//  Shared header fpu_defs.vh:
//   - default exponent width P and subtrahend width W
//   - requester index constants (REQ_ALIGN=0, REQ_NORM=1, REQ_LOG=2)
//  Sub-module rr_arbiter:
//   - N-way round-robin grant with pointer update on an accept pulse
//   - one instance
//  The subtract and pipeline registers stay in this module.
// TESTING
//  1. Reset mid-stream with both stages full -> res_valid=0, busy=0 in the same cycle;
//     the first grant after release goes to requester 0.
//  2. Single request, req0 A=8'h7F, B=5'd3 -> 2 cycles later:
//     res_y=8'h7C, res_borrow=0, res_id=0.
//  3. Underflow, A=8'h02, B=5'd5 -> res_y=8'hFD, res_borrow=1.
//  4. All three requesters valid continuously, res_ready=1 -> grants 0,1,2,0,1,2;
//     one result per cycle.
//  5. res_ready=0 for 4 cycles with 2 requests in flight -> req_ready=0, res_y stable;
//     both results delivered in order once res_ready=1.
//  6. Pointer at 2, only req1 valid -> grant 1, pointer becomes 2.

Source files
------------

// File: rtl/exp_subt_sched_pkg.sv
// Shared constants for the exponent-subtractor scheduler: default operand
// widths and the conventional requester slot assignments.
package exp_subt_sched_pkg;

   // Default exponent width (A operand, Y result) and subtrahend width (B operand).
   localparam int unsigned EXP_P = 8;
   localparam int unsigned EXP_W = 5;

   // Default number of requesters sharing the subtractor.
   localparam int unsigned EXP_N_REQ = 3;

   // Requester slots: add/sub alignment, normalisation, log range-reduction.
   typedef enum logic [1:0] {
      REQ_ALIGN = 2'd0,
      REQ_NORM  = 2'd1,
      REQ_LOG   = 2'd2
   } req_id_e;

endpackage

// File: rtl/exp_subt_sched_rr_arbiter.sv
// N-way round-robin arbiter. The grant is purely combinational from the
// request vector and the pointer; the pointer advances past the granted
// requester only when the caller reports that the grant was taken.
module rr_arbiter
   import exp_subt_sched_pkg::*;
#(
   parameter int N    = EXP_N_REQ,
   parameter int ID_W = $clog2(EXP_N_REQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    i_valid,
   input  logic            i_accept,
   output logic [N-1:0]    o_grant,
   output logic [ID_W-1:0] o_grant_id,
   output logic            o_any
);

   logic [ID_W-1:0] r_ptr;
   logic [N-1:0]    w_grant;
   logic [ID_W-1:0] w_grant_id;
   logic            w_any;

   // Scan requesters starting at the pointer and pick the first valid one.
   always_comb begin
      // NOTE: every output of this block gets a default before the scan, so
      // no path leaves a signal unassigned and no latch is inferred.
      w_grant    = '0;
      w_grant_id = '0;
      w_any      = 1'b0;
      for (int k = 0; k < N; k++) begin
         logic [ID_W-1:0] idx;
         idx = ID_W'((int'(r_ptr) + k) % N);
         if (!w_any && i_valid[idx]) begin
            w_any       = 1'b1;
            w_grant_id  = idx;
            w_grant[idx] = 1'b1;
         end
      end
   end

   // Move the pointer just past the winner, wrapping N-1 -> 0, on a taken grant.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!rst) begin
         r_ptr <= '0;
      end else if (i_accept) begin
         r_ptr <= (int'(w_grant_id) == N - 1) ? '0 : w_grant_id + 1'b1;
      end
   end

   assign o_grant    = w_grant;
   assign o_grant_id = w_grant_id;
   assign o_any      = w_any;

endmodule

// File: rtl/exp_subt_sched.sv
// Shared exponent subtractor Y = A - B for several requesters.
// Round-robin arbitration feeds a two-stage pipeline: S1 holds the accepted
// operands and tag, S2 holds the difference, the borrow and the tag.
module exp_subt_sched
   import exp_subt_sched_pkg::*;
#(
   parameter int P     = EXP_P,
   parameter int W     = EXP_W,
   parameter int N_REQ = EXP_N_REQ,
   parameter int ID_W  = $clog2(EXP_N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*P-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [P-1:0]       res_y,
   output logic               res_borrow,
   output logic [ID_W-1:0]    res_id,
   output logic               busy
);

   localparam int PX = P + 1;

   // Stage 1: operand register.
   logic            r_s1_valid;
   logic [P-1:0]    r_s1_a;
   logic [W-1:0]    r_s1_b;
   logic [ID_W-1:0] r_s1_id;

   // Stage 2: result register.
   logic            r_s2_valid;
   logic [P-1:0]    r_s2_y;
   logic            r_s2_borrow;
   logic [ID_W-1:0] r_s2_id;

   logic [N_REQ-1:0] w_grant;
   logic [ID_W-1:0]  w_grant_id;
   logic             w_any;
   logic             w_advance;
   logic             w_s1_open;
   logic             w_accept;
   logic [P-1:0]     w_sel_a;
   logic [W-1:0]     w_sel_b;
   logic [PX-1:0]    w_diff;

   // S2 can take a new value when it is empty or its result leaves this cycle;
   // S1 can take a new request when it is empty or is moving into S2.
   assign w_advance = !r_s2_valid || res_ready;
   assign w_s1_open = !r_s1_valid || w_advance;

   // Ready depends only on valids, the pointer and the stall state, and is
   // forced low while reset is asserted.
   assign req_ready = rst ? (w_grant & {N_REQ{w_s1_open}}) : '0;
   assign w_accept  = rst && w_any && w_s1_open;

   assign w_sel_a = req_a[int'(w_grant_id) * P +: P];
   assign w_sel_b = req_b[int'(w_grant_id) * W +: W];

   // B is zero-extended; the extra top bit of the (P+1)-bit difference is the borrow.
   assign w_diff = PX'(r_s1_a) - PX'(r_s1_b);

   rr_arbiter #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (req_valid),
      .i_accept   (w_accept),
      .o_grant    (w_grant),
      .o_grant_id (w_grant_id),
      .o_any      (w_any)
   );

   // Stage 1: capture the granted operands; empties when nothing is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_id    <= '0;
      end else if (w_s1_open) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_a  <= w_sel_a;
            r_s1_b  <= w_sel_b;
            r_s1_id <= w_grant_id;
         end
      end
   end

   // Stage 2: register the difference, borrow and tag whenever the result can move.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_y      <= '0;
         r_s2_borrow <= 1'b0;
         r_s2_id     <= '0;
      end else if (w_advance) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_y      <= w_diff[P-1:0];
            r_s2_borrow <= w_diff[P];
            r_s2_id     <= r_s1_id;
         end
      end
   end

   assign res_valid  = r_s2_valid;
   assign res_y      = r_s2_y;
   assign res_borrow = r_s2_borrow;
   assign res_id     = r_s2_id;
   assign busy       = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_exp_subt_sched.sv
// Self-checking bench for exp_subt_sched: a scoreboard records the expected
// result of every accepted request and checks results as they leave, while a
// small round-robin model checks each grant.
module tb_exp_subt_sched;
   import exp_subt_sched_pkg::*;

   localparam int P    = 8;
   localparam int W    = 5;
   localparam int N    = 3;
   localparam int ID_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*P-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic             res_valid;
   logic             res_ready;
   logic [P-1:0]     res_y;
   logic             res_borrow;
   logic [ID_W-1:0]  res_id;
   logic             busy;

   typedef struct {
      logic [P-1:0]    y;
      logic            borrow;
      logic [ID_W-1:0] id;
   } exp_t;

   exp_t sb[$];
   int   m_ptr   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   exp_subt_sched #(.P(P), .W(W), .N_REQ(N), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_y      (res_y),
      .res_borrow (res_borrow),
      .res_id     (res_id),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_op(input int i, input logic [P-1:0] a, input logic [W-1:0] b);
      req_a[i*P +: P] = a;
      req_b[i*W +: W] = b;
   endtask

   // One clock: observe handshakes at the falling edge, then update stimulus
   // just after the rising edge. Accepted requesters are re-armed with fresh
   // operands (rearm=1) or dropped.
   task automatic step(input bit rearm, output logic [N-1:0] acc);
      @(negedge clk);
      acc = req_valid & req_ready;
      if (rst) begin
         if (acc != '0) begin
            int gid;
            int eid;
            exp_t e;
            logic [P-1:0] a;
            logic [P-1:0] b;
            gid = 0;
            eid = -1;
            for (int i = 0; i < N; i++) if (acc[i]) gid = i;
            for (int k = 0; k < N; k++)
               if (eid < 0 && req_valid[(m_ptr + k) % N]) eid = (m_ptr + k) % N;
            check("grant_onehot", $countones(acc), 1);
            check("grant_rr", gid, eid);
            m_ptr = (gid + 1) % N;
            a = req_a[gid*P +: P];
            b = P'(req_b[gid*W +: W]);
            e.y      = a - b;
            e.borrow = (a < b);
            e.id     = ID_W'(gid);
            sb.push_back(e);
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("res_y", res_y, e.y);
               check("res_borrow", res_borrow, e.borrow);
               check("res_id", res_id, e.id);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            if (rearm) set_op(i, P'($urandom), W'($urandom));
            else req_valid[i] = 1'b0;
         end
      end
   endtask

   // Run until every request and result has left the design, within a bound.
   task automatic drain();
      logic [N-1:0] acc;
      int n;
      n = 0;
      while ((sb.size() != 0 || busy || req_valid != '0) && n < 30) begin
         step(1'b0, acc);
         n++;
      end
      check("drain_done", (sb.size() == 0 && !busy && req_valid == '0), 1);
   endtask

   initial begin
      logic [N-1:0] acc;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;

      // Reset state, with requests asserted to show ready stays low.
      repeat (2) @(posedge clk);
      #1;
      req_valid = 3'b111;
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_res_y", res_y, 0);
      check("rst_res_borrow", res_borrow, 0);
      check("rst_res_id", res_id, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single request: two-cycle latency, 7F - 3 = 7C.
      set_op(REQ_ALIGN, 8'h7F, 5'd3);
      req_valid = 3'b001;
      step(1'b0, acc);
      check("t2_accept", acc, 3'b001);
      check("t2_lat_early", res_valid, 0);
      step(1'b0, acc);
      check("t2_valid", res_valid, 1);
      check("t2_y", res_y, 8'h7C);
      check("t2_borrow", res_borrow, 0);
      check("t2_id", res_id, REQ_ALIGN);
      drain();

      // Underflow: 02 - 5 = FD with borrow.
      set_op(0, 8'h02, 5'd5);
      req_valid = 3'b001;
      step(1'b0, acc);
      step(1'b0, acc);
      check("t3_y", res_y, 8'hFD);
      check("t3_borrow", res_borrow, 1);
      drain();

      // Back-pressure: pointer is at 1, so req1 then req0 fill the pipe.
      res_ready = 1'b0;
      set_op(0, 8'h40, 5'h10);
      set_op(1, 8'h10, 5'h1F);
      req_valid = 3'b011;
      step(1'b0, acc);
      check("t5_first", acc, 3'b010);
      step(1'b0, acc);
      check("t5_second", acc, 3'b001);
      set_op(2, 8'hAA, 5'h0A);
      req_valid = 3'b100;
      for (int c = 0; c < 4; c++) begin
         check("t5_stall_ready", req_ready, 0);
         check("t5_stall_y", res_y, 8'hF1);
         check("t5_stall_valid", res_valid, 1);
         step(1'b0, acc);
      end
      res_ready = 1'b1;
      drain();

      // Reset with both stages full: outputs clear at once, nothing replays.
      res_ready = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, P'($urandom), W'($urandom));
      req_valid = 3'b111;
      step(1'b0, acc);
      step(1'b0, acc);
      check("t1_full", busy, 1);
      rst = 1'b0;
      #1;
      check("t1_res_valid", res_valid, 0);
      check("t1_busy", busy, 0);
      check("t1_req_ready", req_ready, 0);
      sb.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) set_op(i, P'($urandom), W'($urandom));
      req_valid = 3'b111;
      @(posedge clk);
      #1;
      rst = 1'b1;
      res_ready = 1'b1;

      // Continuous traffic: grants 0,1,2,... and one result every cycle.
      for (int k = 0; k < 12; k++) begin
         step(1'b1, acc);
         check("t4_grant", acc, 3'b001 << (k % N));
         if (k >= 1) check("t4_res_every_cycle", res_valid, 1);
      end
      req_valid = '0;
      drain();

      // Pointer at 2 with only req1 valid: req1 wins, pointer returns to 2.
      set_op(1, 8'h33, 5'h03);
      req_valid = 3'b010;
      step(1'b0, acc);
      drain();
      set_op(1, 8'h20, 5'h1F);
      req_valid = 3'b010;
      #1;
      check("t6_ready", req_ready, 3'b010);
      step(1'b0, acc);
      check("t6_grant", acc, 3'b010);
      for (int i = 0; i < N; i++) set_op(i, P'($urandom), W'($urandom));
      req_valid = 3'b111;
      #1;
      check("t6_ptr_after", req_ready, 3'b100);
      step(1'b0, acc);
      req_valid = '0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
